// File: rtl/exe_mem_skid.sv
// rtl/exe_mem_skid.sv - EX->MEM pipeline stage with a two-entry skid buffer and flush
// in_ready is registered, so a MEM stall reaches EX one cycle late; the skid entry absorbs that in-flight accept.
module exe_mem_skid #(
  parameter int CTRL_W = 3,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [REG_W-1:0]  in_wreg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_wdata,
  output logic [REG_W-1:0]  out_wreg,
  output logic [1:0]        occupancy
);

  logic              mainValid;
  logic [CTRL_W-1:0] mainCtrl;
  logic [DATA_W-1:0] mainAlu;
  logic [DATA_W-1:0] mainWdata;
  logic [REG_W-1:0]  mainWreg;

  logic              skidValid;
  logic [CTRL_W-1:0] skidCtrl;
  logic [DATA_W-1:0] skidAlu;
  logic [DATA_W-1:0] skidWdata;
  logic [REG_W-1:0]  skidWreg;

  logic accept;
  logic consume;

  assign accept  = in_valid & ~skidValid;
  assign consume = mainValid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      mainValid <= 1'b0;
      mainCtrl  <= '0;
      mainAlu   <= '0;
      mainWdata <= '0;
      mainWreg  <= '0;
      skidValid <= 1'b0;
      skidCtrl  <= '0;
      skidAlu   <= '0;
      skidWdata <= '0;
      skidWreg  <= '0;
    end else if (flush) begin
      // Data registers keep stale contents; only the valid bits matter after a squash.
      mainValid <= 1'b0;
      skidValid <= 1'b0;
    end else begin
      case ({mainValid, skidValid})
        2'b00: begin
          if (accept) begin
            mainValid <= 1'b1;
            mainCtrl  <= in_ctrl;
            mainAlu   <= in_alu;
            mainWdata <= in_wdata;
            mainWreg  <= in_wreg;
          end
        end
        2'b10: begin
          if (accept && consume) begin
            mainCtrl  <= in_ctrl;
            mainAlu   <= in_alu;
            mainWdata <= in_wdata;
            mainWreg  <= in_wreg;
          end else if (accept) begin
            skidValid <= 1'b1;
            skidCtrl  <= in_ctrl;
            skidAlu   <= in_alu;
            skidWdata <= in_wdata;
            skidWreg  <= in_wreg;
          end else if (consume) begin
            mainValid <= 1'b0;
          end
        end
        2'b11: begin
          if (consume) begin
            skidValid <= 1'b0;
            mainCtrl  <= skidCtrl;
            mainAlu   <= skidAlu;
            mainWdata <= skidWdata;
            mainWreg  <= skidWreg;
          end
        end
        default: begin
          mainValid <= 1'b0;
          skidValid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = ~skidValid;
  assign out_valid = mainValid;
  assign out_ctrl  = mainValid ? mainCtrl : '0;
  assign out_alu   = mainAlu;
  assign out_wdata = mainWdata;
  assign out_wreg  = mainWreg;
  assign occupancy = {1'b0, mainValid} + {1'b0, skidValid};

endmodule

// File: tb/tb_exe_mem_skid.sv
// tb/tb_exe_mem_skid.sv - randomized bench for exe_mem_skid against a queue model
module tb_exe_mem_skid;
  localparam int CTRL_W = 3;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] wdata;
    logic [REG_W-1:0]  wreg;
  } entry_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_alu;
  logic [DATA_W-1:0] in_wdata;
  logic [REG_W-1:0]  in_wreg;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_alu;
  logic [DATA_W-1:0] out_wdata;
  logic [REG_W-1:0]  out_wreg;
  logic [1:0]        occupancy;

  int nCompared = 0;
  int nMismatched = 0;
  entry_t q[$];

  exe_mem_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_alu(in_alu), .in_wdata(in_wdata), .in_wreg(in_wreg),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_alu(out_alu), .out_wdata(out_wdata), .out_wreg(out_wreg),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkModel();
    entry_t head;
    check("out_valid", 64'(out_valid), 64'(q.size() != 0));
    check("occupancy", 64'(occupancy), 64'(q.size()));
    check("in_ready", 64'(in_ready), 64'(q.size() < 2));
    if (q.size() != 0) begin
      head = q[0];
      check("out_ctrl", 64'(out_ctrl), 64'(head.ctrl));
      check("out_alu", 64'(out_alu), 64'(head.alu));
      check("out_wdata", 64'(out_wdata), 64'(head.wdata));
      check("out_wreg", 64'(out_wreg), 64'(head.wreg));
    end else begin
      check("out_ctrl_bubble", 64'(out_ctrl), 64'd0);
    end
  endtask

  // Model: a FIFO of at most two entries, updated from the inputs seen at each edge.
  task automatic cycle();
    entry_t e;
    bit acc;
    bit con;
    @(posedge clk);
    e = '{ctrl: in_ctrl, alu: in_alu, wdata: in_wdata, wreg: in_wreg};
    acc = in_valid && (q.size() < 2);
    con = (q.size() > 0) && out_ready;
    if (rst || flush) begin
      q.delete();
    end else begin
      if (con) q.delete(0);
      if (acc) q.push_back(e);
    end
    @(negedge clk);
    checkModel();
  endtask

  task automatic push(input logic [DATA_W-1:0] alu, input logic ready);
    in_valid  = 1'b1;
    in_ctrl   = CTRL_W'($urandom);
    in_alu    = alu;
    in_wdata  = $urandom;
    in_wreg   = REG_W'($urandom);
    out_ready = ready;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 3'b101; in_alu = 32'h1234; in_wdata = 32'h5678; in_wreg = 5'd7;

    // Reset held two cycles with an entry offered
    for (int i = 0; i < 2; i++) begin
      cycle();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_alu", 64'(out_alu), 64'd0);
      check("rst_out_wdata", 64'(out_wdata), 64'd0);
      check("rst_out_wreg", 64'(out_wreg), 64'd0);
      check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_occupancy", 64'(occupancy), 64'd0);
    end
    rst = 1'b0;
    cycle();
    check("first_accept_alu", 64'(out_alu), 64'h1234);
    check("first_accept_valid", 64'(out_valid), 64'd1);

    // Streaming
    out_ready = 1'b1; in_valid = 1'b0;
    cycle();
    for (int i = 1; i <= 3; i++) begin
      push(DATA_W'(i * 16), 1'b1);
      cycle();
      check("stream_alu", 64'(out_alu), 64'(i * 16));
      check("stream_occ", 64'(occupancy), 64'd1);
      check("stream_ready", 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    cycle();

    // Stall into skid, then drain in order
    push(32'hA, 1'b0); cycle();
    push(32'hB, 1'b0); cycle();
    check("stall_occ", 64'(occupancy), 64'd2);
    check("stall_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    check("drain_second", 64'(out_alu), 64'hB);
    check("drain_ready", 64'(in_ready), 64'd1);
    cycle();
    check("drain_empty", 64'(out_valid), 64'd0);

    // Bubble: ctrl driven but nothing valid
    in_valid = 1'b0; in_ctrl = 3'b111;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bubble_ctrl", 64'(out_ctrl), 64'd0);
    end

    // Flush while full with an incoming entry D
    push(32'hA1, 1'b0); cycle();
    push(32'hB1, 1'b0); cycle();
    push(32'hD, 1'b0); flush = 1'b1;
    cycle();
    check("flush_occ", 64'(occupancy), 64'd0);
    check("flush_ctrl", 64'(out_ctrl), 64'd0);
    check("flush_ready", 64'(in_ready), 64'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("flush_no_d", 64'(out_valid), 64'd0);
    end

    // Random traffic; in_alu is a sequence number so loss or duplication shows up
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      flush     = ($urandom_range(0, 99) < 5);
      rst       = ($urandom_range(0, 999) == 0);
      in_ctrl   = CTRL_W'($urandom);
      in_alu    = 32'(i);
      in_wdata  = $urandom;
      in_wreg   = REG_W'($urandom);
      cycle();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
